serial_pattern_tx: RTL and testbench

Serial pattern transmitter: accepts a WIDTH-bit pattern word with a repeat count and inter-repetition gap, then drives it MSB-first onto a one-bit stream with a per-bit qualifier. Forms the transmit end of the team's serial pattern link and feeds the `identicator` 1011 detector: `tx_bit` drives its `in`, and `tx_start` drives its `start`. Used as stimulus source and in-system pattern generator.

---
 rtl/serial_pattern_pkg.sv | 17 +
 rtl/serial_pattern_tx.sv | 129 ++++++++++++
 tb/tb_serial_pattern_tx.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_pkg.sv
// Shared definitions for the serial pattern link: FSM state encoding and the
// default 1011 pattern shared with the identicator detector.
package serial_pattern_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND,
    GAP  = ST_GAP
  } tx_state_t;

  localparam logic [3:0] PATTERN_1011 = 4'b1011;

endpackage

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a WIDTH-bit word MSB-first, repeated with
// optional idle gaps, with a per-bit qualifier and an end-of-transfer pulse.
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_word,
  input  logic [CNT_W-1:0] load_repeat,
  input  logic [GAP_W-1:0] load_gap,
  input  logic             abort,
  output logic             tx_bit,
  output logic             tx_start,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  tx_state_t        state_q;
  logic [WIDTH-1:0] word_q;
  logic [IDX_W-1:0] bit_idx_q;
  logic [CNT_W-1:0] rep_left_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             tx_bit_q;
  logic             tx_start_q;
  logic             busy_q;
  logic             done_q;
  logic [IDX_W-1:0] idx_next;

  assign load_ready = (state_q == IDLE) & ~abort;
  assign idx_next   = bit_idx_q - 1'b1;

  assign tx_bit   = tx_bit_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // bit_idx_q always names the bit currently on tx_bit, so the next bit is
  // fetched one index lower at each SEND edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      bit_idx_q  <= '0;
      rep_left_q <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      tx_bit_q   <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (abort) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      rep_left_q <= '0;
      gap_cnt_q  <= '0;
      tx_bit_q   <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            state_q    <= SEND;
            word_q     <= load_word;
            gap_q      <= load_gap;
            rep_left_q <= (load_repeat == '0) ? CNT_W'(1) : load_repeat;
            bit_idx_q  <= LAST_IDX;
            tx_bit_q   <= load_word[WIDTH-1];
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        SEND: begin
          if (bit_idx_q != '0) begin
            bit_idx_q <= idx_next;
            tx_bit_q  <= word_q[idx_next];
          end else begin
            rep_left_q <= rep_left_q - 1'b1;
            if (rep_left_q == CNT_W'(1)) begin
              state_q    <= IDLE;
              tx_bit_q   <= 1'b0;
              tx_start_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else if (gap_q != '0) begin
              state_q    <= GAP;
              gap_cnt_q  <= gap_q;
              tx_bit_q   <= 1'b0;
              tx_start_q <= 1'b0;
            end else begin
              bit_idx_q <= LAST_IDX;
              tx_bit_q  <= word_q[WIDTH-1];
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_W'(1)) begin
            state_q    <= SEND;
            gap_cnt_q  <= '0;
            bit_idx_q  <= LAST_IDX;
            tx_bit_q   <= word_q[WIDTH-1];
            tx_start_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          tx_bit_q   <= 1'b0;
          tx_start_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: single, repeated/gapped, zero-repeat,
// abort, back-to-back and asynchronous-reset scenarios.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [3:0] load_word = 4'b0;
  logic [7:0] load_repeat = 8'd0;
  logic [3:0] load_gap = 4'd0;
  logic       abort = 1'b0;
  logic       tx_bit, tx_start, busy, done;

  int checks = 0;
  int failures = 0;

  serial_pattern_tx #(.WIDTH(4), .CNT_W(8), .GAP_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_word(load_word), .load_repeat(load_repeat), .load_gap(load_gap),
    .abort(abort),
    .tx_bit(tx_bit), .tx_start(tx_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge; on return the bench sits in cycle T+1.
  task automatic start_load(input logic [3:0] w, input logic [7:0] r, input logic [3:0] g);
    load_word = w; load_repeat = r; load_gap = g; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({tx_bit, tx_start, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000", {tx_bit, tx_start, busy, done});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (load_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", load_ready);
    end
  endtask

  task automatic test_single();
    logic [3:0] w;
    w = 4'b1011;
    start_load(w, 8'd1, 4'd0);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({tx_start, tx_bit, busy, done} !== {1'b1, w[3-c], 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL single_bit c=%0d got=%b exp=%b", c, {tx_start, tx_bit, busy, done}, {1'b1, w[3-c], 1'b1, 1'b0});
      end
      tick();
    end
    checks++;
    if ({tx_start, tx_bit, busy, done, load_ready} !== 5'b00011) begin
      failures++;
      $display("FAIL single_done got=%b exp=00011", {tx_start, tx_bit, busy, done, load_ready});
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL single_done_pulse got=%b exp=0", done);
    end
  endtask

  task automatic test_repeat_gap();
    logic [3:0] w;
    logic       es, eb;
    int         k;
    w = 4'b1011;
    start_load(w, 8'd3, 4'd2);
    for (int c = 1; c <= 16; c++) begin
      k = (c - 1) % 6;
      es = (k < 4);
      eb = es ? w[3-k] : 1'b0;
      checks++;
      if ({tx_start, tx_bit, busy, done} !== {es, eb, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL repgap c=T+%0d got=%b exp=%b", c, {tx_start, tx_bit, busy, done}, {es, eb, 1'b1, 1'b0});
      end
      tick();
    end
    checks++;
    if ({tx_start, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL repgap_done got=%b exp=001", {tx_start, busy, done});
    end
    tick();
  endtask

  task automatic test_repeat_zero();
    logic [3:0] w;
    w = 4'b0110;
    start_load(w, 8'd0, 4'd3);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({tx_start, tx_bit, done} !== {1'b1, w[3-c], 1'b0}) begin
        failures++;
        $display("FAIL rep0_bit c=%0d got=%b exp=%b", c, {tx_start, tx_bit, done}, {1'b1, w[3-c], 1'b0});
      end
      tick();
    end
    checks++;
    if ({tx_start, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL rep0_done got=%b exp=001", {tx_start, busy, done});
    end
    tick();
  endtask

  task automatic test_abort();
    logic [3:0] w;
    w = 4'b1011;
    start_load(w, 8'd5, 4'd0);
    tick();
    abort = 1'b1;
    tick();
    checks++;
    if ({tx_start, tx_bit, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL abort_stop got=%b exp=0000", {tx_start, tx_bit, busy, done});
    end
    load_word = 4'b1011; load_repeat = 8'd5; load_gap = 4'd0; load_valid = 1'b1;
    #1;
    checks++;
    if (load_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_ready got=%b exp=0", load_ready);
    end
    tick();
    checks++;
    if ({tx_start, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL abort_blocks_load got=%b exp=000", {tx_start, busy, done});
    end
    abort = 1'b0;
    tick();
    load_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if ({tx_start, tx_bit, done} !== {1'b1, w[3-(c%4)], 1'b0}) begin
        failures++;
        $display("FAIL abort_reload c=%0d got=%b exp=%b", c, {tx_start, tx_bit, done}, {1'b1, w[3-(c%4)], 1'b0});
      end
      tick();
    end
    checks++;
    if ({tx_start, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL abort_reload_done got=%b exp=001", {tx_start, busy, done});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] a, b;
    logic       es, eb;
    int         k;
    a = 4'b1011;
    b = 4'b0110;
    load_word = a; load_repeat = 8'd2; load_gap = 4'd1; load_valid = 1'b1;
    tick();
    load_word = b; load_repeat = 8'd1; load_gap = 4'd0;
    for (int c = 1; c <= 9; c++) begin
      k = (c - 1) % 5;
      es = (k < 4);
      eb = es ? a[3-k] : 1'b0;
      checks++;
      if ({tx_start, tx_bit, busy, done, load_ready} !== {es, eb, 1'b1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL b2b_first c=T+%0d got=%b exp=%b", c, {tx_start, tx_bit, busy, done, load_ready}, {es, eb, 1'b1, 1'b0, 1'b0});
      end
      tick();
    end
    checks++;
    if ({tx_start, busy, done, load_ready} !== 4'b0011) begin
      failures++;
      $display("FAIL b2b_done got=%b exp=0011", {tx_start, busy, done, load_ready});
    end
    tick();
    load_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({tx_start, tx_bit, busy} !== {1'b1, b[3-c], 1'b1}) begin
        failures++;
        $display("FAIL b2b_second c=%0d got=%b exp=%b", c, {tx_start, tx_bit, busy}, {1'b1, b[3-c], 1'b1});
      end
      tick();
    end
    checks++;
    if ({tx_start, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL b2b_second_done got=%b exp=001", {tx_start, busy, done});
    end
    tick();
  endtask

  task automatic test_reset_mid_gap();
    logic [3:0] w;
    w = 4'b1011;
    start_load(w, 8'd2, 4'd3);
    repeat (5) tick();
    checks++;
    if ({tx_start, tx_bit, busy} !== 3'b001) begin
      failures++;
      $display("FAIL gap_state got=%b exp=001", {tx_start, tx_bit, busy});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_start, tx_bit, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset got=%b exp=0000", {tx_start, tx_bit, busy, done});
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({load_ready, busy, done} !== 3'b100) begin
      failures++;
      $display("FAIL post_reset got=%b exp=100", {load_ready, busy, done});
    end
    start_load(w, 8'd1, 4'd0);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({tx_start, tx_bit} !== {1'b1, w[3-c]}) begin
        failures++;
        $display("FAIL post_reset_bit c=%0d got=%b exp=%b", c, {tx_start, tx_bit}, {1'b1, w[3-c]});
      end
      tick();
    end
    checks++;
    if ({tx_start, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL post_reset_done got=%b exp=001", {tx_start, busy, done});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat_gap();
    test_repeat_zero();
    test_abort();
    test_back_to_back();
    test_reset_mid_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
